// File: rtl/rf_wb_scheduler_pkg.sv
// Shared constants for the regfile writeback scheduler.
// Requester indices fix each execute unit's position in the round-robin order.
package rf_pkg;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NREGS = 2 ** AW;
  localparam int NREQ  = 3;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_MDU = 2;
endpackage

// File: rtl/rf_wb_scheduler_rr_arbiter.sv
// N-way round-robin arbiter: the scan starts just after the last winner.
// The pointer moves only when a grant is issued.
module rr_arbiter
  import rf_pkg::*;
#(
  parameter int N  = rf_pkg::NREQ,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic          any_grant,
  output logic [PW-1:0] grant_idx
);

  logic [PW-1:0] ptr;

  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PW'(idx);
      end
    end
  end

  // Reset to the last index so requester 0 is first in line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= PW'(N - 1);
    end else if (any_grant) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Regfile write-port scheduler: round-robin writeback plus a per-register
// busy scoreboard that decode uses for RAW/WAW stalls.
module rf_wb_scheduler
  import rf_pkg::*;
#(
  parameter int NREQ = rf_pkg::NREQ,
  parameter int DW   = rf_pkg::DW,
  parameter int AW   = rf_pkg::AW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*AW-1:0]  req_addr,
  input  logic [NREQ*DW-1:0]  req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic                rf_we,
  output logic [AW-1:0]       rf_waddr,
  output logic [DW-1:0]       rf_wdata,
  input  logic                rsv_valid,
  input  logic [AW-1:0]       rsv_addr,
  output logic                rsv_ok,
  input  logic [AW-1:0]       chk_addr1,
  input  logic [AW-1:0]       chk_addr2,
  output logic                chk_busy1,
  output logic                chk_busy2,
  output logic [2**AW-1:0]    busy_vec
);

  localparam int NR = 2 ** AW;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic          any_grant;
  logic [PW-1:0] grant_idx;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic [NR-1:0] busy_nxt;

  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .grant     (req_ready),
    .any_grant (any_grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_addr = req_addr[int'(grant_idx)*AW +: AW];
    sel_data = req_data[int'(grant_idx)*DW +: DW];
  end

  // r0 is hardwired; a granted write to it is consumed without a commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= any_grant && (sel_addr != '0);
      if (any_grant) begin
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
      end
    end
  end

  assign rsv_ok    = rsv_valid & ~busy_vec[rsv_addr];
  assign chk_busy1 = busy_vec[chk_addr1];
  assign chk_busy2 = busy_vec[chk_addr2];

  // A clear and a reserve of the same register cannot coincide: the
  // register is still busy, so rsv_ok is already low in that cycle.
  always_comb begin
    busy_nxt = busy_vec;
    if (rf_we) busy_nxt[rf_waddr] = 1'b0;
    if (rsv_ok) busy_nxt[rsv_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_vec <= '0;
    end else begin
      busy_vec <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler: inputs change on the falling edge,
// registered outputs are checked on the falling edge after the update.
module tb_rf_wb_scheduler;
  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int AW   = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DW-1:0]     rf_wdata;
  logic              rsv_valid;
  logic [AW-1:0]     rsv_addr;
  logic              rsv_ok;
  logic [AW-1:0]     chk_addr1, chk_addr2;
  logic              chk_busy1, chk_busy2;
  logic [2**AW-1:0]  busy_vec;

  int n_checks = 0;
  int n_fail   = 0;

  rf_wb_scheduler #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rsv_ok    (rsv_ok),
    .chk_addr1 (chk_addr1),
    .chk_addr2 (chk_addr2),
    .chk_busy1 (chk_busy1),
    .chk_busy2 (chk_busy2),
    .busy_vec  (busy_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0; req_addr = '0; req_data = '0;
    rsv_valid = 1'b0; rsv_addr = '0;
    chk_addr1 = '0; chk_addr2 = '0;
    #12;
    chk("reset_we", rf_we, 0);
    chk("reset_waddr", rf_waddr, 0);
    chk("reset_wdata", rf_wdata, 0);
    chk("reset_busy", busy_vec, 0);
    nxt(); rst = 1'b0;

    // Reset in the middle of a writeback
    nxt(); rsv_valid = 1'b1; rsv_addr = 5'd5;
    #1 chk("mid_rsv_ok", rsv_ok, 1);
    nxt(); rsv_valid = 1'b0;
    chk("mid_busy5", busy_vec[5], 1);
    req_valid = 3'b010; set_req(1, 5'd5, 32'h1234);
    #1 chk("mid_ready", req_ready, 3'b010);
    nxt(); req_valid = '0;
    chk("mid_we_pre", rf_we, 1);
    rst = 1'b1;
    #1 chk("mid_we_rst", rf_we, 0);
    chk("mid_busy_rst", busy_vec, 0);
    chk("mid_waddr_rst", rf_waddr, 0);

    // Round-robin with all three valid
    nxt(); rst = 1'b0;
    req_valid = 3'b111;
    set_req(0, 5'd1, 32'hA1); set_req(1, 5'd2, 32'hA2); set_req(2, 5'd3, 32'hA3);
    #1 chk("rr_g0", req_ready, 3'b001);
    nxt(); chk("rr_wa0", rf_waddr, 1); chk("rr_wd0", rf_wdata, 32'hA1); chk("rr_we0", rf_we, 1);
    #1 chk("rr_g1", req_ready, 3'b010);
    nxt(); chk("rr_wa1", rf_waddr, 2); chk("rr_wd1", rf_wdata, 32'hA2);
    #1 chk("rr_g2", req_ready, 3'b100);
    nxt(); chk("rr_wa2", rf_waddr, 3); chk("rr_wd2", rf_wdata, 32'hA3);
    #1 chk("rr_g3", req_ready, 3'b001);
    nxt(); chk("rr_wa3", rf_waddr, 1);
    req_valid = '0;
    #1 chk("rr_idle_ready", req_ready, 0);
    nxt(); chk("rr_idle_we", rf_we, 0); chk("rr_hold_waddr", rf_waddr, 1);
    chk("rr_busy_untouched", busy_vec, 0);

    // Single writer with reservation and RAW check
    rsv_valid = 1'b1; rsv_addr = 5'd5; chk_addr1 = 5'd5;
    #1 chk("sw_rsv_ok", rsv_ok, 1);
    chk("sw_chk_pre", chk_busy1, 0);
    nxt(); rsv_valid = 1'b0;
    chk("sw_busy5", busy_vec[5], 1);
    req_valid = 3'b001; set_req(0, 5'd5, 32'hDEADBEEF);
    #1 chk("sw_ready", req_ready, 3'b001);
    chk("sw_chk_busy", chk_busy1, 1);
    nxt(); req_valid = '0;
    chk("sw_we", rf_we, 1); chk("sw_waddr", rf_waddr, 5); chk("sw_wdata", rf_wdata, 32'hDEADBEEF);
    chk("sw_chk_during", chk_busy1, 1);
    nxt(); chk("sw_chk_after", chk_busy1, 0);
    chk("sw_we_off", rf_we, 0); chk("sw_hold_wdata", rf_wdata, 32'hDEADBEEF);

    // WAW stall on r7
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    #1 chk("waw_first_ok", rsv_ok, 1);
    nxt(); #1 chk("waw_stall0", rsv_ok, 0);
    req_valid = 3'b100; set_req(2, 5'd7, 32'h77);
    #1 chk("waw_ready", req_ready, 3'b100);
    nxt(); req_valid = '0;
    chk("waw_we", rf_we, 1); chk("waw_waddr", rf_waddr, 7);
    #1 chk("waw_stall_commit", rsv_ok, 0);
    nxt(); #1 chk("waw_retry_ok", rsv_ok, 1);
    nxt(); rsv_valid = 1'b0;
    chk("waw_busy7", busy_vec[7], 1);

    // Same-cycle clear and reserve of r9
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    #1 chk("cr_rsv_ok", rsv_ok, 1);
    nxt(); rsv_valid = 1'b0;
    req_valid = 3'b001; set_req(0, 5'd9, 32'h9);
    #1 chk("cr_ready", req_ready, 3'b001);
    nxt(); req_valid = '0;
    chk("cr_we", rf_we, 1); chk("cr_waddr", rf_waddr, 9);
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    #1 chk("cr_same_cycle", rsv_ok, 0);
    nxt(); #1 chk("cr_retry_ok", rsv_ok, 1);
    nxt(); rsv_valid = 1'b0;
    chk("cr_busy9", busy_vec[9], 1);
    chk("cr_busy7_kept", busy_vec[7], 1);

    // r0 handling
    req_valid = 3'b010; set_req(1, 5'd0, 32'hFFFFFFFF);
    rsv_valid = 1'b1; rsv_addr = 5'd0; chk_addr2 = 5'd0;
    #1 chk("r0_ready", req_ready, 3'b010);
    chk("r0_rsv_ok", rsv_ok, 1);
    chk("r0_chk", chk_busy2, 0);
    nxt(); req_valid = '0; rsv_valid = 1'b0;
    chk("r0_we", rf_we, 0);
    chk("r0_busy0", busy_vec[0], 0);
    chk("r0_busy_vec", busy_vec, 32'h0000_0280);

    nxt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
- Shares the single register-file write port between NREQ writeback requesters (ALU=0, LSU=1, MDU=2) using round-robin arbitration.
- Keeps a per-register busy scoreboard: issue reserves a destination register, and the reservation clears when the write commits.
- Decode uses the chk_* outputs to stall on RAW hazards.
- Sits between the execute units and the 32x32 regfile: drives its we/waddr/wdata.

Parameters:
- NREQ, 3, number of writeback requesters
- DW, 32, data width
- AW, 5, register address width (NREGS = 2**AW)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  NREQ  requester i has a result
- req_addr  in  NREQ*AW  destination register of requester i; slice i = [i*AW +: AW]
- req_data  in  NREQ*DW  result of requester i; slice i = [i*DW +: DW]
- req_ready  out  NREQ  one-hot grant; handshake when valid & ready
- rf_we  out  1  regfile write enable (registered)
- rf_waddr  out  AW  regfile write address (registered)
- rf_wdata  out  DW  regfile write data (registered)
- rsv_valid  in  1  issue requests reservation of rsv_addr
- rsv_addr  in  AW  destination register to reserve
- rsv_ok  out  1  reservation accepted this cycle (combinational)
- chk_addr1  in  AW  decode source 1
- chk_addr2  in  AW  decode source 2
- chk_busy1  out  1  source 1 has a pending write
- chk_busy2  out  1  source 2 has a pending write
- busy_vec  out  2**AW  scoreboard, debug

Behaviour:
- Reset values, applied asynchronously:
  - rf_we=0, rf_waddr=0, rf_wdata=0
  - busy_vec all 0
  - rr pointer = NREQ-1, so requester 0 wins first
  - A write accepted but not yet committed is dropped.
- Arbitration (combinational within the cycle):
  - Scan starts at ptr+1 modulo NREQ; the first valid requester is granted.
  - req_ready is one-hot or zero; no valid requester means req_ready=0.
  - ptr updates to the granted index only on a grant.
  - The write port never back-pressures: a lone valid requester is always granted in the same cycle.
- Writeback latency:
  - A handshake in cycle N gives rf_we=1 with rf_waddr/rf_wdata = granted addr/data in cycle N+1.
  - The regfile commits at the end of N+1.
  - With no handshake, rf_we=0 in N+1; rf_waddr/rf_wdata hold their previous values.
- Address 0:
  - A request to r0 is handshaken normally, but rf_we stays 0 in N+1.
  - busy_vec[0] is constantly 0.
  - rsv to r0 gives rsv_ok=1 with no state change.
- Reservation:
  - rsv_ok = rsv_valid & ~busy_vec[rsv_addr]; a reservation on a busy register is refused (WAW stall).
  - On rsv_ok, busy_vec[rsv_addr] is set at the clock edge.
- Clear:
  - busy_vec[rf_waddr] clears at the edge ending a cycle with rf_we=1, which is the same edge the regfile writes.
  - This guarantees chk_busy=0 only once the regfile holds the new value.
- Simultaneous clear and reserve of the same register in one cycle: rsv_ok=0, because the register is still busy. The clear wins; the reserve retries next cycle.
- A write to a non-reserved register is legal; it commits and leaves busy unchanged.
- chk_busyK = busy_vec[chk_addrK], combinational; r0 always reads 0.

Decomposition:
- Package rf_pkg:
  - AW, DW, NREGS, NREQ
  - requester index constants REQ_ALU=0, REQ_LSU=1, REQ_MDU=2
- Sub-module rr_arbiter: NREQ-wide round-robin with req/grant/pointer update on accept.
- Scoreboard and output registers live in the top level.

Test Plan:
- Reset mid-write: rsv r5 ok, then req_valid[1] with r5/0x1234 handshakes, then rst asserted in the next cycle -> rf_we=0 immediately, busy_vec=0, ptr restored, so with all valid after rst the grant order is 0,1,2.
- Single writer: rsv r5 (rsv_ok=1, busy_vec[5]=1 next cycle); req_valid[0] r5/0xDEADBEEF -> req_ready=001 the same cycle, then rf_we=1/r5/0xDEADBEEF the next cycle, then chk_busy1 for r5 = 0 the cycle after.
- Round-robin fairness: all three valid continuously with addrs r1,r2,r3 -> grants 001,010,100,001 on successive cycles; rf_waddr sequence 1,2,3,1.
- WAW stall: r7 busy, rsv r7 -> rsv_ok=0 until the cycle after the commit of r7, then rsv_ok=1.
- Same-cycle clear and reserve: rf_we=1 to r9 while rsv r9 -> rsv_ok=0 that cycle; retry next cycle gives rsv_ok=1 and busy_vec[9]=1.
- r0 handling: req to r0 with data 0xFFFFFFFF -> req_ready=1, rf_we stays 0; rsv r0 -> rsv_ok=1, busy_vec[0]=0; chk r0 -> busy 0.
